lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/lsu_stage_pkg.sv | 30 +++
 rtl/lsu_load_fmt.sv | 27 ++
 rtl/lsu_stage.sv | 153 +++++++++++++++
 tb/tb_lsu_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: widths, MemOP codes, CLINT window
// and FSM state encoding.
package lsu_stage_pkg;

    localparam int RegWidth = 64;
    localparam int INSTWide = 32;

    // MemOP: [1:0] access size (1/2/4/8 bytes), [2] zero-extend; 3'b011 means no access
    localparam logic [2:0] MEMOP_LB   = 3'b000;
    localparam logic [2:0] MEMOP_LH   = 3'b001;
    localparam logic [2:0] MEMOP_LW   = 3'b010;
    localparam logic [2:0] MEMOP_NONE = 3'b011;
    localparam logic [2:0] MEMOP_LBU  = 3'b100;
    localparam logic [2:0] MEMOP_LHU  = 3'b101;
    localparam logic [2:0] MEMOP_LWU  = 3'b110;
    localparam logic [2:0] MEMOP_LD   = 3'b111;

    localparam logic [RegWidth-1:0] CLINT_BASE = 64'h0000_0000_0200_0000;
    localparam logic [RegWidth-1:0] CLINT_LAST = 64'h0000_0000_0200_BFFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HAVE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    function automatic logic is_clint(input logic [RegWidth-1:0] addr);
        return (addr >= CLINT_BASE) && (addr <= CLINT_LAST);
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: selects the addressed bytes of an aligned doubleword and
// sign/zero-extends them according to MemOP.
module lsu_load_fmt
    import lsu_stage_pkg::*;
(
    input  logic [RegWidth-1:0] raw,
    input  logic [2:0]          offset,
    input  logic [2:0]          memop,
    output logic [RegWidth-1:0] data
);

    logic [RegWidth-1:0] shifted;
    logic                zext;

    always_comb begin
        shifted = raw >> {offset, 3'b000};
        zext    = memop[2];
        data    = shifted;
        case (memop[1:0])
            2'd0: data = zext ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1: data = zext ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: data = zext ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage: holds one instruction, waits for dcache load data or
// performs CLINT accesses, and hands formatted results to writeback.
module lsu_stage
    import lsu_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                exu_to_lsu_valid,
    output logic                lsu_allow_in,
    input  logic [2:0]          i_MemOP,
    input  logic                i_MemWr,
    input  logic [RegWidth-1:0] i_ALUres,
    input  logic [RegWidth-1:0] i_R_rs2,
    input  logic                i_RegWr,
    input  logic [1:0]          i_RegSrc,
    input  logic [INSTWide-1:0] i_inst,
    input  logic [RegWidth-1:0] i_pc,
    input  logic [RegWidth-1:0] i_R_rs1,
    input  logic                i_isecall,
    input  logic                i_ismret,
    input  logic                i_iscsr,
    input  logic                cache_rvalid,
    input  logic [63:0]         cache_rdata,
    output logic                stall_exu_store,
    output logic                clint_en,
    output logic                clint_we,
    output logic [63:0]         clint_addr,
    output logic [63:0]         clint_wdata,
    input  logic [63:0]         clint_rdata,
    input  logic                pipeline_flush,
    input  logic                wbu_allow_in,
    output logic                lsu_to_wbu_valid,
    output logic                o_RegWr,
    output logic [1:0]          o_RegSrc,
    output logic [RegWidth-1:0] o_ALUres,
    output logic [RegWidth-1:0] o_MemData,
    output logic [INSTWide-1:0] o_inst,
    output logic [RegWidth-1:0] o_pc,
    output logic [RegWidth-1:0] o_R_rs1,
    output logic                o_isecall,
    output logic                o_ismret,
    output logic                o_iscsr,
    output logic [1:0]          lsu_state
);

    // Handshakes: a transfer happens on a posedge where valid & ready are both high;
    // valid never depends on ready, and the producer holds its data while valid & ~ready.
    logic                lsu_valid;
    logic [1:0]          state, state_nxt;
    logic [63:0]         buffer;
    logic [2:0]          mem_op;
    logic                mem_wr;
    logic [RegWidth-1:0] rs2_data;

    logic isclint, has_mem, isload, ready_go, handoff, capture, cap_cache_load;
    logic [63:0] raw;

    assign isclint        = is_clint(o_ALUres);
    assign has_mem        = (mem_op != MEMOP_NONE);
    assign isload         = lsu_valid & has_mem & ~mem_wr & ~isclint;
    assign cap_cache_load = (i_MemOP != MEMOP_NONE) & ~i_MemWr & ~is_clint(i_ALUres);

    assign ready_go = isload ? (((state == ST_WAIT) & cache_rvalid) | (state == ST_HAVE)) : 1'b1;

    assign lsu_to_wbu_valid = lsu_valid & ready_go;
    assign handoff          = lsu_to_wbu_valid & wbu_allow_in;
    assign lsu_allow_in     = (state != ST_DRAIN) & (~lsu_valid | (ready_go & wbu_allow_in));
    assign capture          = exu_to_lsu_valid & lsu_allow_in;

    assign stall_exu_store = (state == ST_WAIT) | (state == ST_DRAIN);
    assign lsu_state       = state;

    assign clint_en    = lsu_valid & isclint & has_mem;
    assign clint_we    = handoff & isclint & mem_wr;
    assign clint_addr  = o_ALUres;
    assign clint_wdata = rs2_data;

    assign raw = isclint ? clint_rdata : ((state == ST_WAIT) ? cache_rdata : buffer);

    lsu_load_fmt u_load_fmt (
        .raw    (raw),
        .offset (o_ALUres[2:0]),
        .memop  (mem_op),
        .data   (o_MemData)
    );

    always_comb begin
        state_nxt = state;
        if (pipeline_flush) begin
            // A response arriving in the flush cycle itself is already consumed,
            // so only an outstanding one needs draining.
            case (state)
                ST_WAIT, ST_DRAIN: state_nxt = cache_rvalid ? ST_IDLE : ST_DRAIN;
                default:           state_nxt = ST_IDLE;
            endcase
        end else if (state == ST_DRAIN) begin
            if (cache_rvalid) state_nxt = ST_IDLE;
        end else if (capture) begin
            state_nxt = cap_cache_load ? ST_WAIT : ST_IDLE;
        end else if ((state == ST_WAIT) && cache_rvalid && !wbu_allow_in) begin
            state_nxt = ST_HAVE;
        end else if (handoff) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_valid <= 1'b0;
            state     <= ST_IDLE;
            buffer    <= '0;
            mem_op    <= '0;
            mem_wr    <= 1'b0;
            rs2_data  <= '0;
            o_RegWr   <= 1'b0;
            o_RegSrc  <= '0;
            o_ALUres  <= '0;
            o_inst    <= '0;
            o_pc      <= '0;
            o_R_rs1   <= '0;
            o_isecall <= 1'b0;
            o_ismret  <= 1'b0;
            o_iscsr   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pipeline_flush)
                lsu_valid <= 1'b0;
            else if (capture)
                lsu_valid <= 1'b1;
            else if (handoff)
                lsu_valid <= 1'b0;

            if ((state == ST_WAIT) && cache_rvalid && !wbu_allow_in && !pipeline_flush)
                buffer <= cache_rdata;

            if (capture && !pipeline_flush) begin
                mem_op    <= i_MemOP;
                mem_wr    <= i_MemWr;
                rs2_data  <= i_R_rs2;
                o_RegWr   <= i_RegWr;
                o_RegSrc  <= i_RegSrc;
                o_ALUres  <= i_ALUres;
                o_inst    <= i_inst;
                o_pc      <= i_pc;
                o_R_rs1   <= i_R_rs1;
                o_isecall <= i_isecall;
                o_ismret  <= i_ismret;
                o_iscsr   <= i_iscsr;
            end
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: loads, buffered loads, flush drain, CLINT store/load,
// back-to-back ALU stream and reset mid-load.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_to_lsu_valid;
    logic        lsu_allow_in;
    logic [2:0]  i_MemOP;
    logic        i_MemWr;
    logic [63:0] i_ALUres, i_R_rs2, i_pc, i_R_rs1;
    logic        i_RegWr;
    logic [1:0]  i_RegSrc;
    logic [31:0] i_inst;
    logic        i_isecall, i_ismret, i_iscsr;
    logic        cache_rvalid;
    logic [63:0] cache_rdata;
    logic        stall_exu_store;
    logic        clint_en, clint_we;
    logic [63:0] clint_addr, clint_wdata, clint_rdata;
    logic        pipeline_flush;
    logic        wbu_allow_in;
    logic        lsu_to_wbu_valid;
    logic        o_RegWr;
    logic [1:0]  o_RegSrc;
    logic [63:0] o_ALUres, o_MemData, o_pc, o_R_rs1;
    logic [31:0] o_inst;
    logic        o_isecall, o_ismret, o_iscsr;
    logic [1:0]  lsu_state;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int we_base;
    logic [31:0] exp_q[$];

    lsu_stage dut (
        .clk(clk), .rst(rst),
        .exu_to_lsu_valid(exu_to_lsu_valid), .lsu_allow_in(lsu_allow_in),
        .i_MemOP(i_MemOP), .i_MemWr(i_MemWr), .i_ALUres(i_ALUres), .i_R_rs2(i_R_rs2),
        .i_RegWr(i_RegWr), .i_RegSrc(i_RegSrc), .i_inst(i_inst), .i_pc(i_pc),
        .i_R_rs1(i_R_rs1), .i_isecall(i_isecall), .i_ismret(i_ismret), .i_iscsr(i_iscsr),
        .cache_rvalid(cache_rvalid), .cache_rdata(cache_rdata),
        .stall_exu_store(stall_exu_store),
        .clint_en(clint_en), .clint_we(clint_we), .clint_addr(clint_addr),
        .clint_wdata(clint_wdata), .clint_rdata(clint_rdata),
        .pipeline_flush(pipeline_flush),
        .wbu_allow_in(wbu_allow_in), .lsu_to_wbu_valid(lsu_to_wbu_valid),
        .o_RegWr(o_RegWr), .o_RegSrc(o_RegSrc), .o_ALUres(o_ALUres), .o_MemData(o_MemData),
        .o_inst(o_inst), .o_pc(o_pc), .o_R_rs1(o_R_rs1),
        .o_isecall(o_isecall), .o_ismret(o_ismret), .o_iscsr(o_iscsr),
        .lsu_state(lsu_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    always @(posedge clk) if (clint_we) we_cnt = we_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [2:0] op, input logic wr,
                          input logic [63:0] addr, input logic [63:0] rs2, input logic [31:0] inst);
        exu_to_lsu_valid = v;
        i_MemOP  = op;
        i_MemWr  = wr;
        i_ALUres = addr;
        i_R_rs2  = rs2;
        i_inst   = inst;
    endtask

    initial begin
        rst = 1'b1;
        set_op(1'b0, 3'b011, 1'b0, 64'h0, 64'h0, 32'h0);
        i_RegWr = 1'b0; i_RegSrc = 2'd0; i_pc = 64'h0; i_R_rs1 = 64'h0;
        i_isecall = 1'b0; i_ismret = 1'b0; i_iscsr = 1'b0;
        cache_rvalid = 1'b0; cache_rdata = 64'h0; clint_rdata = 64'h0;
        pipeline_flush = 1'b0; wbu_allow_in = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
        check("rst_allow", {63'b0, lsu_allow_in}, 64'd1);
        check("rst_state", {62'b0, lsu_state}, 64'd0);
        check("rst_stall", {63'b0, stall_exu_store}, 64'd0);
        check("rst_alures", o_ALUres, 64'h0);
        check("rst_memdata", o_MemData, 64'h0);

        // lb with zero-cycle passthrough of the response
        set_op(1'b1, 3'b000, 1'b0, 64'h8000_0003, 64'h0, 32'h0000_0003);
        i_RegWr = 1'b1;
        tick();
        exu_to_lsu_valid = 1'b0;
        cache_rvalid = 1'b1; cache_rdata = 64'h0000_0000_80FF_0000;
        @(negedge clk);
        check("lb_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
        check("lb_data", o_MemData, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_state", {62'b0, lsu_state}, 64'd1);
        check("lb_stall", {63'b0, stall_exu_store}, 64'd1);
        check("lb_regwr", {63'b0, o_RegWr}, 64'd1);
        tick();
        cache_rvalid = 1'b0;
        @(negedge clk);
        check("lb_done_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
        check("lb_done_state", {62'b0, lsu_state}, 64'd0);

        // lhu buffered while writeback is blocked
        i_RegWr = 1'b0;
        set_op(1'b1, 3'b101, 1'b0, 64'h8000_0104, 64'h0, 32'h0000_0005);
        wbu_allow_in = 1'b0;
        tick();
        exu_to_lsu_valid = 1'b0;
        cache_rvalid = 1'b1; cache_rdata = 64'h1234_8765_0000_0000;
        @(negedge clk);
        check("lhu_data_wait", o_MemData, 64'h0000_0000_0000_8765);
        check("lhu_valid_wait", {63'b0, lsu_to_wbu_valid}, 64'd1);
        tick();
        cache_rvalid = 1'b0; cache_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("lhu_state_have", {62'b0, lsu_state}, 64'd2);
            check("lhu_data_have", o_MemData, 64'h0000_0000_0000_8765);
            check("lhu_allow_have", {63'b0, lsu_allow_in}, 64'd0);
            check("lhu_stall_have", {63'b0, stall_exu_store}, 64'd0);
            tick();
        end
        wbu_allow_in = 1'b1;
        @(negedge clk);
        check("lhu_handoff_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
        check("lhu_handoff_allow", {63'b0, lsu_allow_in}, 64'd1);
        tick();
        @(negedge clk);
        check("lhu_after_state", {62'b0, lsu_state}, 64'd0);
        check("lhu_after_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);

        // flush while waiting: the late response is drained and dropped
        set_op(1'b1, 3'b111, 1'b0, 64'h8000_0010, 64'h0, 32'h0000_0007);
        tick();
        exu_to_lsu_valid = 1'b0;
        pipeline_flush = 1'b1;
        tick();
        pipeline_flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("drain_state", {62'b0, lsu_state}, 64'd3);
            check("drain_allow", {63'b0, lsu_allow_in}, 64'd0);
            check("drain_stall", {63'b0, stall_exu_store}, 64'd1);
            check("drain_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
            tick();
        end
        cache_rvalid = 1'b1;
        @(negedge clk);
        check("drain_rvalid_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
        tick();
        cache_rvalid = 1'b0;
        @(negedge clk);
        check("drain_exit_state", {62'b0, lsu_state}, 64'd0);
        check("drain_exit_stall", {63'b0, stall_exu_store}, 64'd0);

        // CLINT store: one write, at the handoff
        we_base = we_cnt;
        set_op(1'b1, 3'b111, 1'b1, 64'h0200_4000, 64'hAB, 32'h0000_0009);
        wbu_allow_in = 1'b0;
        tick();
        exu_to_lsu_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("sd_en", {63'b0, clint_en}, 64'd1);
            check("sd_we_blocked", {63'b0, clint_we}, 64'd0);
            check("sd_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
            check("sd_addr", clint_addr, 64'h0200_4000);
            check("sd_wdata", clint_wdata, 64'hAB);
            tick();
        end
        wbu_allow_in = 1'b1;
        @(negedge clk);
        check("sd_we_handoff", {63'b0, clint_we}, 64'd1);
        tick();
        @(negedge clk);
        check("sd_we_after", {63'b0, clint_we}, 64'd0);
        check("sd_we_count", 64'(we_cnt - we_base), 64'd1);

        // CLINT lw at the top of the window, then lbu just past it goes to the cache
        set_op(1'b1, 3'b010, 1'b0, 64'h0200_BFFC, 64'h0, 32'h0000_000B);
        clint_rdata = 64'hF000_0001_0000_0000;
        tick();
        exu_to_lsu_valid = 1'b0;
        @(negedge clk);
        check("clw_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
        check("clw_data", o_MemData, 64'hFFFF_FFFF_F000_0001);
        check("clw_en", {63'b0, clint_en}, 64'd1);
        check("clw_state", {62'b0, lsu_state}, 64'd0);
        set_op(1'b1, 3'b100, 1'b0, 64'h0200_C000, 64'h0, 32'h0000_000D);
        tick();
        exu_to_lsu_valid = 1'b0;
        @(negedge clk);
        check("lbu_edge_state", {62'b0, lsu_state}, 64'd1);
        check("lbu_edge_en", {63'b0, clint_en}, 64'd0);
        cache_rvalid = 1'b1; cache_rdata = 64'h0000_0000_0000_00AA;
        #1;
        check("lbu_edge_data", o_MemData, 64'h0000_0000_0000_00AA);
        tick();
        cache_rvalid = 1'b0;

        // back-to-back ALU ops, one per cycle
        for (int k = 0; k < 4; k++) begin
            set_op(1'b1, 3'b011, 1'b0, 64'(k), 64'h0, 32'h0000_0013 + 32'(k << 7));
            exp_q.push_back(32'h0000_0013 + 32'(k << 7));
            tick();
            @(negedge clk);
            check("addi_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
            check("addi_allow", {63'b0, lsu_allow_in}, 64'd1);
            check("addi_inst", {32'b0, o_inst}, {32'b0, exp_q.pop_front()});
        end

        // reset in the middle of a load wait
        set_op(1'b1, 3'b111, 1'b0, 64'h8000_0020, 64'h0, 32'h0000_0003);
        tick();
        exu_to_lsu_valid = 1'b0;
        @(negedge clk);
        check("rstw_state", {62'b0, lsu_state}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstw_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
        check("rstw_state_idle", {62'b0, lsu_state}, 64'd0);
        check("rstw_inst", {32'b0, o_inst}, 64'd0);
        cache_rvalid = 1'b1;
        tick();
        @(negedge clk);
        check("stray_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
        check("stray_state", {62'b0, lsu_state}, 64'd0);
        cache_rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
